reg_writeback: RTL and testbench

Write-back stage register that captures execute-stage results (y1/y2 channel writes), waits for load data when required, and presents one committed write set per cycle to the register file and the data-bypass unit. It is the producer end of the bypass interface: its `back_*` outputs are the "write-back modified" data and flags that the bypass muxes prefer over register-file contents. It has one capture slot and sustains one instruction per cycle when no load wait is involved.

---
 rtl/reg_writeback.sv | 219 +++++++++++++++++++++
 tb/tb_reg_writeback.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
//
// Write-back stage register. It captures one execute-stage result (a y1
// channel write and a y2 channel write). When y1 is a load, it waits for the
// memory return. It then presents the committed write set for exactly one
// cycle to the register file and to the bypass muxes.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   ex_valid / ex_ready : execute-stage handshake (ex_ready is registered)
//   y1_channel[3:0]     : y1 target (0 none, 1-6 r1-r6, 7 cs, 8 ds, 9 flag,
//                         10 pc, 11 tpc, 12 ipc, 13 sp, 14 tlb, 15 sys)
//   y2_channel[1:0]     : y2 target (0 none, 1 flag, 2 sp, 3 none)
//   y1_data, y2_data    : result data
//   y1_is_load          : y1 data comes from mem_rdata instead of y1_data
//   mem_rvalid/mem_rdata: load return
//   flush               : discard any uncommitted result
//   sys_info[2]         : when set, writes to channel 14 (tlb) are dropped
//   back_y1_ch/data     : committed y1 write
//   back_y2_ch/data     : committed y2 write, channel expanded to 9 / 13
//   back_c[15:0]        : per-channel commit mask, bit 0 always 0
// ---------------------------------------------------------------------------
module reg_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [3:0]  y1_channel,
    input  logic [1:0]  y2_channel,
    input  logic [31:0] y1_data,
    input  logic [31:0] y2_data,
    input  logic        y1_is_load,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        flush,
    input  logic [31:0] sys_info,
    output logic [3:0]  back_y1_ch,
    output logic [31:0] back_y1_data,
    output logic [3:0]  back_y2_ch,
    output logic [31:0] back_y2_data,
    output logic [15:0] back_c
);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        WAIT_MEM = 2'd1,
        DRAIN    = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        ex_ready_q, ex_ready_d;

    // Fields of a load that is waiting for its memory return.
    logic [3:0]  pend_y1_ch_q, pend_y1_ch_d;
    logic [3:0]  pend_y2_ch_q, pend_y2_ch_d;
    logic [31:0] pend_y2_data_q, pend_y2_data_d;

    // Registered commit outputs.
    logic [3:0]  back_y1_ch_q, back_y1_ch_d;
    logic [3:0]  back_y2_ch_q, back_y2_ch_d;
    logic [31:0] back_y1_data_q, back_y1_data_d;
    logic [31:0] back_y2_data_q, back_y2_data_d;
    logic [15:0] back_c_q, back_c_d;

    // Only sys_info[2] carries meaning here.
    logic        unused_sys_bits;
    assign unused_sys_bits = ^{sys_info[31:3], sys_info[1:0]};

    // ---------------------------------------------------------------------
    // Capture-time channel decode
    // ---------------------------------------------------------------------
    logic [3:0]  cap_y2_ch;
    logic [3:0]  cap_y1_ch;
    logic        cap_wait;
    logic [15:0] cap_mask;
    logic [15:0] pend_mask;

    always_comb begin
        cap_y2_ch = 4'd0;
        case (y2_channel)
            2'd1:    cap_y2_ch = 4'd9;
            2'd2:    cap_y2_ch = 4'd13;
            default: cap_y2_ch = 4'd0;
        endcase

        cap_y1_ch = y1_channel;
        // pc and sys are never written from here. tlb writes can be locked
        // out by sys_info[2].
        if (y1_channel == 4'd10 || y1_channel == 4'd15 ||
            (y1_channel == 4'd14 && sys_info[2])) begin
            cap_y1_ch = 4'd0;
        end
        // Same-channel conflict: y2 wins, the same priority as the bypass.
        if (cap_y1_ch == cap_y2_ch) begin
            cap_y1_ch = 4'd0;
        end
    end

    // A load waits for its memory return even when its y1 write was
    // suppressed. This consumes the return beat.
    assign cap_wait = y1_is_load && (y1_channel != 4'd0);

    // Commit masks: bit n is set when either write targets channel n.
    assign cap_mask[0]  = 1'b0;
    assign pend_mask[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 16; gi++) begin : g_mask
            assign cap_mask[gi]  = (cap_y1_ch == 4'(gi)) || (cap_y2_ch == 4'(gi));
            assign pend_mask[gi] = (pend_y1_ch_q == 4'(gi)) || (pend_y2_ch_q == 4'(gi));
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        pend_y1_ch_d   = pend_y1_ch_q;
        pend_y2_ch_d   = pend_y2_ch_q;
        pend_y2_data_d = pend_y2_data_q;
        back_y1_ch_d   = 4'd0;
        back_y2_ch_d   = 4'd0;
        back_c_d       = 16'd0;
        back_y1_data_d = back_y1_data_q;
        back_y2_data_d = back_y2_data_q;

        case (state_q)
            EMPTY, HOLD: begin
                // flush also blocks capture. The HOLD commit already shown
                // this cycle is architectural and is not affected.
                if (ex_valid && !flush) begin
                    if (cap_wait) begin
                        state_d        = WAIT_MEM;
                        pend_y1_ch_d   = cap_y1_ch;
                        pend_y2_ch_d   = cap_y2_ch;
                        pend_y2_data_d = y2_data;
                    end else begin
                        state_d        = HOLD;
                        back_y1_ch_d   = cap_y1_ch;
                        back_y2_ch_d   = cap_y2_ch;
                        back_y1_data_d = y1_data;
                        back_y2_data_d = y2_data;
                        back_c_d       = cap_mask;
                    end
                end else begin
                    state_d = EMPTY;
                end
            end

            WAIT_MEM: begin
                if (mem_rvalid) begin
                    if (flush) begin
                        state_d = EMPTY;
                    end else begin
                        state_d        = HOLD;
                        back_y1_ch_d   = pend_y1_ch_q;
                        back_y2_ch_d   = pend_y2_ch_q;
                        back_y1_data_d = mem_rdata;
                        back_y2_data_d = pend_y2_data_q;
                        back_c_d       = pend_mask;
                    end
                end else if (flush) begin
                    // The load is still outstanding. Its return must be
                    // swallowed before new work is accepted.
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                if (mem_rvalid) begin
                    state_d = EMPTY;
                end
            end

            default: state_d = EMPTY;
        endcase

        ex_ready_d = (state_d == EMPTY) || (state_d == HOLD);
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= EMPTY;
            ex_ready_q     <= 1'b1;
            pend_y1_ch_q   <= 4'd0;
            pend_y2_ch_q   <= 4'd0;
            pend_y2_data_q <= 32'd0;
            back_y1_ch_q   <= 4'd0;
            back_y2_ch_q   <= 4'd0;
            back_y1_data_q <= 32'd0;
            back_y2_data_q <= 32'd0;
            back_c_q       <= 16'd0;
        end else begin
            state_q        <= state_d;
            ex_ready_q     <= ex_ready_d;
            pend_y1_ch_q   <= pend_y1_ch_d;
            pend_y2_ch_q   <= pend_y2_ch_d;
            pend_y2_data_q <= pend_y2_data_d;
            back_y1_ch_q   <= back_y1_ch_d;
            back_y2_ch_q   <= back_y2_ch_d;
            back_y1_data_q <= back_y1_data_d;
            back_y2_data_q <= back_y2_data_d;
            back_c_q       <= back_c_d;
        end
    end

    assign ex_ready     = ex_ready_q;
    assign back_y1_ch   = back_y1_ch_q;
    assign back_y2_ch   = back_y2_ch_q;
    assign back_y1_data = back_y1_data_q;
    assign back_y2_data = back_y2_data_q;
    assign back_c       = back_c_q;

endmodule

// File: tb/tb_reg_writeback.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback
//
// Directed testbench for reg_writeback. A transaction-level reference model
// tracks whether a load is outstanding or being discarded, and the write set
// that must be visible next cycle. A compare process checks every DUT output
// against the model on each falling edge. Directed sequences add
// hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [3:0]  y1_channel = 4'd0;
    logic [1:0]  y2_channel = 2'd0;
    logic [31:0] y1_data = 32'd0;
    logic [31:0] y2_data = 32'd0;
    logic        y1_is_load = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        flush = 1'b0;
    logic [31:0] sys_info = 32'd0;
    logic [3:0]  back_y1_ch;
    logic [31:0] back_y1_data;
    logic [3:0]  back_y2_ch;
    logic [31:0] back_y2_data;
    logic [15:0] back_c;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    reg_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .y1_channel   (y1_channel),
        .y2_channel   (y2_channel),
        .y1_data      (y1_data),
        .y2_data      (y2_data),
        .y1_is_load   (y1_is_load),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .flush        (flush),
        .sys_info     (sys_info),
        .back_y1_ch   (back_y1_ch),
        .back_y1_data (back_y1_data),
        .back_y2_ch   (back_y2_ch),
        .back_y2_data (back_y2_data),
        .back_c       (back_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] y2_map(input logic [1:0] c);
        if (c == 2'd1) return 4'd9;
        if (c == 2'd2) return 4'd13;
        return 4'd0;
    endfunction

    function automatic logic [3:0] y1_eff(input logic [3:0] c, input logic lock_tlb, input logic [3:0] y2c);
        if (c == 4'd10 || c == 4'd15 || (c == 4'd14 && lock_tlb)) return 4'd0;
        if (c == y2c) return 4'd0;
        return c;
    endfunction

    function automatic logic [15:0] commit_mask(input logic [3:0] a, input logic [3:0] b);
        logic [15:0] m;
        m = (16'd1 << a) | (16'd1 << b);
        m[0] = 1'b0;
        return m;
    endfunction

    logic        m_wait, m_drain;
    logic [3:0]  p_y1, p_y2;
    logic [31:0] p_y2d;
    logic [15:0] m_c;
    logic [3:0]  m_y1ch, m_y2ch;
    logic [31:0] m_y1d, m_y2d;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait <= 1'b0; m_drain <= 1'b0;
            p_y1 <= 4'd0; p_y2 <= 4'd0; p_y2d <= 32'd0;
            m_c <= 16'd0; m_y1ch <= 4'd0; m_y2ch <= 4'd0;
            m_y1d <= 32'd0; m_y2d <= 32'd0;
        end else begin
            m_c <= 16'd0; m_y1ch <= 4'd0; m_y2ch <= 4'd0;
            if (m_wait) begin
                if (mem_rvalid) begin
                    m_wait <= 1'b0;
                    if (!flush) begin
                        m_y1ch <= p_y1; m_y2ch <= p_y2;
                        m_y1d <= mem_rdata; m_y2d <= p_y2d;
                        m_c <= commit_mask(p_y1, p_y2);
                    end
                end else if (flush) begin
                    m_wait <= 1'b0; m_drain <= 1'b1;
                end
            end else if (m_drain) begin
                if (mem_rvalid) m_drain <= 1'b0;
            end else if (ex_valid && !flush) begin
                if (y1_is_load && y1_channel != 4'd0) begin
                    m_wait <= 1'b1;
                    p_y1  <= y1_eff(y1_channel, sys_info[2], y2_map(y2_channel));
                    p_y2  <= y2_map(y2_channel);
                    p_y2d <= y2_data;
                end else begin
                    m_y1ch <= y1_eff(y1_channel, sys_info[2], y2_map(y2_channel));
                    m_y2ch <= y2_map(y2_channel);
                    m_y1d  <= y1_data; m_y2d <= y2_data;
                    m_c    <= commit_mask(y1_eff(y1_channel, sys_info[2], y2_map(y2_channel)),
                                          y2_map(y2_channel));
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("ex_ready", {31'd0, ex_ready}, {31'd0, !(m_wait || m_drain)});
            check("back_c", {16'd0, back_c}, {16'd0, m_c});
            check("back_y1_ch", {28'd0, back_y1_ch}, {28'd0, m_y1ch});
            check("back_y2_ch", {28'd0, back_y2_ch}, {28'd0, m_y2ch});
            if (m_y1ch != 4'd0) check("back_y1_data", back_y1_data, m_y1d);
            if (m_y2ch != 4'd0) check("back_y2_data", back_y2_data, m_y2d);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic offer(input logic [3:0] c1, input logic [31:0] d1,
                         input logic [1:0] c2, input logic [31:0] d2, input logic ld);
        ex_valid = 1'b1; y1_channel = c1; y1_data = d1;
        y2_channel = c2; y2_data = d2; y1_is_load = ld;
    endtask

    task automatic idle();
        ex_valid = 1'b0; y1_is_load = 1'b0; y1_channel = 4'd0; y2_channel = 2'd0;
    endtask

    initial begin
        repeat (2) cyc();
        rst = 1'b0;
        check("rst ex_ready", {31'd0, ex_ready}, 32'd1);
        check("rst back_c", {16'd0, back_c}, 32'd0);
        check("rst back_y1_ch", {28'd0, back_y1_ch}, 32'd0);
        check("rst back_y2_ch", {28'd0, back_y2_ch}, 32'd0);
        check("rst back_y1_data", back_y1_data, 32'd0);
        check("rst back_y2_data", back_y2_data, 32'd0);
        chk_en = 1'b1;

        // T1: r3 + flag
        offer(4'd3, 32'h11111111, 2'd1, 32'h5, 1'b0);
        cyc(); idle();
        $display("T1 r3+flag: back_c=0x%0h y1=%0d y2=%0d", back_c, back_y1_ch, back_y2_ch);
        check("t1 back_c", {16'd0, back_c}, 32'h0208);
        check("t1 y1_ch", {28'd0, back_y1_ch}, 32'd3);
        check("t1 y2_ch", {28'd0, back_y2_ch}, 32'd9);
        check("t1 y2_data", back_y2_data, 32'h5);
        cyc();
        check("t1 idle back_c", {16'd0, back_c}, 32'd0);

        // T2: load sp, return three cycles later
        offer(4'd13, 32'h0, 2'd0, 32'h0, 1'b1);
        cyc(); idle();
        check("t2 ready c1", {31'd0, ex_ready}, 32'd0);
        cyc();
        check("t2 ready c2", {31'd0, ex_ready}, 32'd0);
        cyc();
        check("t2 ready c3", {31'd0, ex_ready}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        cyc(); mem_rvalid = 1'b0;
        $display("T2 load sp: back_c=0x%0h y1_data=0x%0h", back_c, back_y1_data);
        check("t2 back_c", {16'd0, back_c}, 32'h2000);
        check("t2 y1_data", back_y1_data, 32'hDEADBEEF);
        check("t2 ready after", {31'd0, ex_ready}, 32'd1);
        cyc();
        check("t2 single cycle", {16'd0, back_c}, 32'd0);

        // T3: y1 sp vs y2 sp conflict
        offer(4'd13, 32'hAAAA0000, 2'd2, 32'h1234, 1'b0);
        cyc(); idle();
        $display("T3 sp conflict: back_c=0x%0h y1=%0d y2=%0d", back_c, back_y1_ch, back_y2_ch);
        check("t3 back_c", {16'd0, back_c}, 32'h2000);
        check("t3 y1_ch", {28'd0, back_y1_ch}, 32'd0);
        check("t3 y2_data", back_y2_data, 32'h1234);
        cyc();

        // T4: tlb write locked, then unlocked
        sys_info = 32'h4;
        offer(4'd14, 32'h77, 2'd0, 32'h0, 1'b0);
        cyc(); idle();
        $display("T4a tlb locked: back_c=0x%0h", back_c);
        check("t4 locked", {16'd0, back_c}, 32'd0);
        sys_info = 32'h0;
        offer(4'd14, 32'h77, 2'd0, 32'h0, 1'b0);
        cyc(); idle();
        $display("T4b tlb open: back_c=0x%0h", back_c);
        check("t4 open", {16'd0, back_c}, 32'h4000);
        cyc();

        // T5: load, flush, late return -> nothing commits
        offer(4'd5, 32'h0, 2'd0, 32'h0, 1'b1);
        cyc(); idle(); flush = 1'b1;
        cyc(); flush = 1'b0;
        check("t5 drain ready", {31'd0, ex_ready}, 32'd0);
        cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        cyc(); mem_rvalid = 1'b0;
        $display("T5 flushed load: back_c=0x%0h ex_ready=%0d", back_c, ex_ready);
        check("t5 ready back", {31'd0, ex_ready}, 32'd1);
        check("t5 no commit", {16'd0, back_c}, 32'd0);
        cyc();

        // T6: flush with return in the same cycle
        offer(4'd2, 32'h0, 2'd1, 32'h9, 1'b1);
        cyc(); idle(); flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1;
        cyc(); flush = 1'b0; mem_rvalid = 1'b0;
        $display("T6 flush+rvalid: back_c=0x%0h ex_ready=%0d", back_c, ex_ready);
        check("t6 no commit", {16'd0, back_c}, 32'd0);
        check("t6 ready", {31'd0, ex_ready}, 32'd1);

        // T7: stray return in EMPTY, flag conflict, flush in HOLD
        mem_rvalid = 1'b1;
        cyc(); mem_rvalid = 1'b0;
        check("t7 stray rvalid", {16'd0, back_c}, 32'd0);
        offer(4'd9, 32'h1, 2'd1, 32'h2, 1'b0);
        cyc();
        check("t7 flag conflict", {16'd0, back_c}, 32'h0200);
        offer(4'd1, 32'h3, 2'd0, 32'h0, 1'b0); flush = 1'b1;
        cyc(); idle(); flush = 1'b0;
        $display("T7 flush in HOLD: back_c=0x%0h", back_c);
        check("t7 flush ignored", {16'd0, back_c}, 32'd0);
        cyc();

        // T8: four back-to-back results on r1-r4
        for (int i = 1; i <= 4; i++) begin
            offer(4'(i), 32'h100 + 32'(i), 2'd0, 32'h0, 1'b0);
            cyc();
            $display("T8 r%0d: back_c=0x%0h", i, back_c);
            check("t8 stream", {16'd0, back_c}, 32'd1 << i);
        end
        idle();
        cyc();

        // T9: async reset in the middle of a stream
        offer(4'd5, 32'h55, 2'd0, 32'h0, 1'b0);
        cyc(); offer(4'd6, 32'h66, 2'd0, 32'h0, 1'b0);
        cyc(); offer(4'd1, 32'h11, 2'd0, 32'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        $display("T9 async reset: back_c=0x%0h ex_ready=%0d", back_c, ex_ready);
        check("t9 rst back_c", {16'd0, back_c}, 32'd0);
        check("t9 rst y1_ch", {28'd0, back_y1_ch}, 32'd0);
        check("t9 rst ready", {31'd0, ex_ready}, 32'd1);
        idle();
        cyc(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t9 quiet", {16'd0, back_c}, 32'd0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
